// File: rtl/game_control_fsm.sv
// game_control_fsm
// Per-frame phase sequencer for the player-character datapath. Steps the
// character block through init / idle / register / settle / apply / draw,
// owns the frame-rate tick, and arbitrates the single VGA write port
// between the map renderer and the sprite drawer.
//
// Build option: define GC_DRAW_TIMEOUT_EN to bound each draw phase to
// DRAW_TIMEOUT cycles and report a sticky timeout_err_o. Without it the
// draw phases wait for their done inputs indefinitely.
//
// state       | meaning
// S_WAIT      | game not started; waits for start_i
// S_INIT      | one-cycle init strobe to the character block
// S_IDLE      | frame drawn; waiting for the next frame tick
// S_REG       | latch the requested action/direction
// S_CHECK     | collision detector settles on the latched direction
// S_APPLY     | commit the action
// S_DRAW_MAP  | map renderer owns the VGA port
// S_DRAW_LINK | sprite drawer owns the VGA port

module game_control_fsm #(
    parameter int unsigned FRAME_TICKS  = 833334,
    parameter int unsigned TICK_W       = 20,
    parameter int unsigned DRAW_TIMEOUT = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       map_draw_done_i,
    input  logic       link_draw_done_i,
    output logic       init_o,
    output logic       idle_o,
    output logic       reg_action_o,
    output logic       apply_action_o,
    output logic       draw_map_o,
    output logic       draw_link_o,
    output logic       vga_sel_o,
    output logic [7:0] frame_count_o,
    output logic       frame_overrun_o,
    output logic       timeout_err_o
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_INIT      = 3'd1,
        S_IDLE      = 3'd2,
        S_REG       = 3'd3,
        S_CHECK     = 3'd4,
        S_APPLY     = 3'd5,
        S_DRAW_MAP  = 3'd6,
        S_DRAW_LINK = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              entry_q;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_wrap;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              in_map, in_link;
    logic              map_done_qual, link_done_qual;
    logic              map_timeout, link_timeout;
    logic              map_exit, link_exit;
    logic              tick_take;

    assign in_map  = (state_q == S_DRAW_MAP);
    assign in_link = (state_q == S_DRAW_LINK);

    // entry_q marks the first cycle in a state; a done seen then is the
    // stale level left over from the previous frame and is ignored.
    assign map_done_qual  = in_map  && !entry_q && map_draw_done_i;
    assign link_done_qual = in_link && !entry_q && link_draw_done_i;

    assign map_exit  = map_done_qual  || map_timeout;
    assign link_exit = link_done_qual || link_timeout;

    assign tick_take = (state_q == S_IDLE) && pending_q;
    assign tick_wrap = (tick_cnt_q == TICK_W'(FRAME_TICKS - 1));

`ifdef GC_DRAW_TIMEOUT_EN
    localparam int unsigned TO_W = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;

    logic [TO_W-1:0] phase_cnt_q;
    logic            timeout_q;
    logic            phase_last;

    assign phase_last   = (phase_cnt_q == TO_W'(DRAW_TIMEOUT - 1));
    assign map_timeout  = in_map  && phase_last && !map_done_qual;
    assign link_timeout = in_link && phase_last && !link_done_qual;

    // Per-phase cycle counter restarts on every state change and counts in draw states.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                phase_cnt_q <= '0;
            end else if (in_map || in_link) begin
                phase_cnt_q <= phase_cnt_q + TO_W'(1);
            end
            if (map_timeout || link_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_q;
`else
    assign map_timeout  = 1'b0;
    assign link_timeout = 1'b0;
    // No timeout hardware in this build; DRAW_TIMEOUT is folded into the
    // constant so the parameter list stays identical across both builds.
    assign timeout_err_o = (DRAW_TIMEOUT == 0) && 1'b0;
`endif

    // Phase sequencing; draw states leave only on a qualified done or timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT:      if (start_i) state_d = S_INIT;
            S_INIT:      state_d = S_DRAW_MAP;
            S_IDLE:      if (pending_q) state_d = S_REG;
            S_REG:       state_d = S_CHECK;
            S_CHECK:     state_d = S_APPLY;
            S_APPLY:     state_d = S_DRAW_MAP;
            S_DRAW_MAP:  if (map_exit) state_d = S_DRAW_LINK;
            S_DRAW_LINK: if (link_exit) state_d = S_IDLE;
            default:     state_d = S_WAIT;
        endcase
    end

    // Frame tick, single-entry pending queue, overrun flag and frame counter.
    always_comb begin
        tick_cnt_d  = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        if (state_q == S_WAIT) begin
            pending_d = 1'b0;
        end else begin
            // A wrap coinciding with S_IDLE->S_REG re-arms pending after the
            // old tick is consumed, so it is not an overrun.
            pending_d = (pending_q && !tick_take) || tick_wrap;
            if (tick_wrap && pending_q && !tick_take) begin
                overrun_d = 1'b1;
            end
        end
        if (in_link && link_exit) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // State register and first-cycle marker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_WAIT;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
        end
    end

    // Tick, pending, overrun and frame counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt_q  <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Moore outputs decoded from the registered state only, so reset drops
    // the draw enables and the VGA mux select without waiting for a clock.
    assign init_o          = (state_q == S_INIT);
    assign idle_o          = (state_q == S_IDLE);
    assign reg_action_o    = (state_q == S_REG);
    assign apply_action_o  = (state_q == S_APPLY);
    assign draw_map_o      = in_map;
    assign draw_link_o     = in_link;
    assign vga_sel_o       = in_link;
    assign frame_count_o   = frame_cnt_q;
    assign frame_overrun_o = overrun_q;

endmodule

// File: tb/tb_game_control_fsm.sv
// Bench for game_control_fsm with a short frame (16 cycles). A phase-level
// reference model (phase name, age in phase, absolute cycle count modulo the
// frame length, queued-tick count) predicts every output each cycle.

module tb_game_control_fsm;

    localparam int FT = 16;
    localparam int DT = 64;

    localparam int P_WAIT  = 0;
    localparam int P_INIT  = 1;
    localparam int P_IDLE  = 2;
    localparam int P_REG   = 3;
    localparam int P_CHECK = 4;
    localparam int P_APPLY = 5;
    localparam int P_DMAP  = 6;
    localparam int P_DLINK = 7;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_r, md_r, ld_r;
    logic       init_o, idle_o, reg_action_o, apply_action_o;
    logic       draw_map_o, draw_link_o, vga_sel_o;
    logic [7:0] frame_count_o;
    logic       frame_overrun_o, timeout_err_o;
    logic [16:0] dut_vec;

    int n_total = 0;
    int n_bad   = 0;

    int m_phase, m_age, m_k, m_frames;
    bit m_pend, m_overrun, m_terr;

    game_control_fsm #(
        .FRAME_TICKS (FT),
        .TICK_W      (5),
        .DRAW_TIMEOUT(DT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_r),
        .map_draw_done_i (md_r),
        .link_draw_done_i(ld_r),
        .init_o          (init_o),
        .idle_o          (idle_o),
        .reg_action_o    (reg_action_o),
        .apply_action_o  (apply_action_o),
        .draw_map_o      (draw_map_o),
        .draw_link_o     (draw_link_o),
        .vga_sel_o       (vga_sel_o),
        .frame_count_o   (frame_count_o),
        .frame_overrun_o (frame_overrun_o),
        .timeout_err_o   (timeout_err_o)
    );

    assign dut_vec = {init_o, idle_o, reg_action_o, apply_action_o, draw_map_o,
                      draw_link_o, vga_sel_o, frame_overrun_o, timeout_err_o, frame_count_o};

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = P_WAIT; m_age = 0; m_k = 0; m_frames = 0;
        m_pend = 0; m_overrun = 0; m_terr = 0;
    endtask

    // One clock edge of the reference model using the inputs now applied.
    task automatic model_edge();
        bit wrap, consume, mq, lq, to;
        int np;
        wrap = (m_k % FT) == FT - 1;
        consume = 0; to = 0; np = m_phase;
        mq = md_r && (m_age > 0);
        lq = ld_r && (m_age > 0);
`ifdef GC_DRAW_TIMEOUT_EN
        if ((m_phase == P_DMAP && !mq) || (m_phase == P_DLINK && !lq))
            to = (m_age == DT - 1);
`endif
        case (m_phase)
            P_WAIT:  if (start_r) np = P_INIT;
            P_INIT:  np = P_DMAP;
            P_DMAP:  if (mq || to) np = P_DLINK;
            P_DLINK: if (lq || to) begin np = P_IDLE; m_frames = (m_frames + 1) % 256; end
            P_IDLE:  if (m_pend) begin np = P_REG; consume = 1; end
            P_REG:   np = P_CHECK;
            P_CHECK: np = P_APPLY;
            P_APPLY: np = P_DMAP;
            default: np = P_WAIT;
        endcase
        if (to) m_terr = 1;
        if (m_phase == P_WAIT) begin
            m_pend = 0;
        end else begin
            if (wrap && m_pend && !consume) m_overrun = 1;
            m_pend = (m_pend && !consume) || wrap;
        end
        m_age = (np == m_phase) ? m_age + 1 : 0;
        m_phase = np;
        m_k++;
    endtask

    function automatic logic [16:0] exp_vec();
        return {m_phase == P_INIT, m_phase == P_IDLE, m_phase == P_REG, m_phase == P_APPLY,
                m_phase == P_DMAP, m_phase == P_DLINK, m_phase == P_DLINK,
                m_overrun, m_terr, 8'(m_frames)};
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    // Done inputs follow a per-phase delay in their own draw state and are
    // random noise elsewhere; start is noise once the game is running.
    task automatic drive(input int md_del, input int ld_del);
        md_r    = (m_phase == P_DMAP)  ? (m_age >= md_del) : 1'($urandom_range(0, 1));
        ld_r    = (m_phase == P_DLINK) ? (m_age >= ld_del) : 1'($urandom_range(0, 1));
        start_r = (m_phase == P_WAIT)  ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_r = 1'b0; md_r = 1'b0; ld_r = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        n_total++;
        if (dut_vec !== 17'h0) begin
            n_bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 17'h0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            md_r = 1'($urandom_range(0, 1));
            ld_r = 1'($urandom_range(0, 1));
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL wait_hold cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
        end
        md_r = 1'b0; ld_r = 1'b0;
    endtask

    task automatic test_start();
        start_r = 1'b1;
        step();
        n_total++;
        if (init_o !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL start_init got=%h exp=%h", dut_vec, exp_vec());
        end
        start_r = 1'b0;
        step();
        n_total++;
        if (init_o !== 1'b0 || draw_map_o !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL start_draw_map got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_stale_done();
        int dlink = 0;
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            start_r = 1'b0;
            md_r = (m_phase == P_DMAP) && (m_age >= 3);
            ld_r = 1'b1;
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL stale_step cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
            if (draw_link_o) dlink++;
            if (m_phase == P_IDLE) done = 1;
        end
        n_total++;
        if (!done) begin
            n_bad++; $display("FAIL stale_budget got=%0d exp=%0d", done, 1);
        end
        n_total++;
        if (dlink !== 2) begin
            n_bad++; $display("FAIL stale_link_len got=%0d exp=%0d", dlink, 2);
        end
    endtask

    task automatic test_overrun();
        bit saw_link = 0;
        bit done = 0;
        n_total++;
        if (frame_overrun_o !== 1'b0) begin
            n_bad++; $display("FAIL overrun_pre got=%0d exp=%0d", frame_overrun_o, 0);
        end
        for (int i = 0; i < 400 && !done; i++) begin
            drive(40, 2);
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL overrun_step cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
            if (draw_link_o) saw_link = 1;
            if (saw_link && m_phase == P_IDLE) done = 1;
        end
        n_total++;
        if (!done) begin
            n_bad++; $display("FAIL overrun_budget got=%0d exp=%0d", done, 1);
        end
        n_total++;
        if (frame_overrun_o !== 1'b1) begin
            n_bad++; $display("FAIL overrun_flag got=%0d exp=%0d", frame_overrun_o, 1);
        end
        drive(1, 1);
        step();
        n_total++;
        if (reg_action_o !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL queued_frame got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_normal_frame();
        int fc_exp = (m_frames + 2) % 256;
        int frames_done = 0;
        int reg_cyc = -1;
        bit prev_link = 0;
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            drive(10, 256);
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL normal_step cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
            n_total++;
            if (vga_sel_o && draw_map_o) begin
                n_bad++; $display("FAIL vga_sel_exclusive got=%0d exp=%0d", vga_sel_o, 0);
            end
            if (reg_action_o) reg_cyc = m_k;
            if (apply_action_o && reg_cyc >= 0) begin
                n_total++;
                if (m_k - reg_cyc !== 2) begin
                    n_bad++; $display("FAIL reg_to_apply got=%0d exp=%0d", m_k - reg_cyc, 2);
                end
            end
            if (prev_link && !draw_link_o) frames_done++;
            prev_link = draw_link_o;
            if (frames_done >= 2 && m_phase == P_IDLE) done = 1;
        end
        n_total++;
        if (!done) begin
            n_bad++; $display("FAIL normal_budget got=%0d exp=%0d", frames_done, 2);
        end
        n_total++;
        if (frame_count_o !== 8'(fc_exp)) begin
            n_bad++; $display("FAIL normal_frame_count got=%0d exp=%0d", frame_count_o, fc_exp);
        end
    endtask

    task automatic test_wrap();
        int md_del = 1;
        int ld_del = 1;
        bit seen255 = 0;
        bit done = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (m_phase == P_APPLY || m_phase == P_IDLE) begin
                md_del = $urandom_range(0, 5);
                ld_del = $urandom_range(0, 5);
            end
            drive(md_del, ld_del);
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL wrap_step cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
            if (m_frames == 255) seen255 = 1;
            if (seen255 && m_frames == 0) done = 1;
        end
        n_total++;
        if (!done) begin
            n_bad++; $display("FAIL wrap_budget got=%0d exp=%0d", done, 1);
        end
        n_total++;
        if (frame_count_o !== 8'd0) begin
            n_bad++; $display("FAIL wrap_frame_count got=%0d exp=%0d", frame_count_o, 0);
        end
    endtask

    task automatic test_reset_mid_draw();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            drive(2, 100);
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL pre_reset_step cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
            if (m_frames >= 2 && m_phase == P_DLINK && m_age == 3) done = 1;
        end
        n_total++;
        if (!done || draw_link_o !== 1'b1) begin
            n_bad++; $display("FAIL mid_draw_reach got=%0d exp=%0d", draw_link_o, 1);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_total++;
        if ({draw_link_o, vga_sel_o} !== 2'b00 || frame_count_o !== 8'd0) begin
            n_bad++; $display("FAIL reset_mid_draw got=%b/%0d exp=00/0", {draw_link_o, vga_sel_o}, frame_count_o);
        end
        model_reset();
        start_r = 1'b0; md_r = 1'b0; ld_r = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
        end
    endtask

`ifdef GC_DRAW_TIMEOUT_EN
    task automatic test_timeout();
        int map_cyc = 0;
        bit done = 0;
        start_r = 1'b1; md_r = 1'b0; ld_r = 1'b0;
        step();
        start_r = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            md_r = 1'b0; ld_r = 1'b0;
            step();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL timeout_step cyc=%0d got=%h exp=%h", m_k, dut_vec, exp_vec());
            end
            if (draw_map_o) map_cyc++;
            if (m_phase == P_DLINK) done = 1;
        end
        n_total++;
        if (map_cyc !== DT) begin
            n_bad++; $display("FAIL timeout_map_len got=%0d exp=%0d", map_cyc, DT);
        end
        n_total++;
        if (timeout_err_o !== 1'b1 || draw_link_o !== 1'b1) begin
            n_bad++; $display("FAIL timeout_flag got=%0d/%0d exp=1/1", timeout_err_o, draw_link_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_stale_done();
        test_overrun();
        test_normal_frame();
        test_wrap();
        test_reset_mid_draw();
`ifdef GC_DRAW_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/game_control_fsm.md
# game_control_fsm

Top-level sequencer for the player-character datapath. It steps the character block through its phases once per video frame: init, idle, register action, collision settle, apply action, draw. It also shares the single VGA write port between the map renderer and the character sprite drawer. The block sits between the board-level clock/reset/KEY inputs and the character, collision and map-draw blocks, and owns the frame-rate tick.

## Interface
- FRAME_TICKS, 833334, clock cycles per game frame (50 MHz / 60 Hz); must be ≥ 8
- TICK_W, 20, width of the frame tick counter; must satisfy 2^TICK_W ≥ FRAME_TICKS
- DRAW_TIMEOUT, 4096, cycle limit per draw phase; used only with GC_DRAW_TIMEOUT_EN
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; forces S_WAIT immediately
- start  in  1  level; begins the game from S_WAIT, ignored in all other states
- map_draw_done  in  1  map renderer finished a full frame
- link_draw_done  in  1  character sprite drawer finished 256 pixels
- init, idle, reg_action, apply_action  out  1 each  phase strobes to the character block
- draw_map  out  1  enables the map renderer
- draw_link  out  1  enables the character drawer
- vga_sel  out  1  VGA write mux: 0 = map, 1 = character
- frame_count  out  8  completed frames, wraps 255→0
- frame_overrun  out  1  sticky; a tick arrived while one was already pending
- timeout_err  out  1  sticky draw-timeout flag; tied 0 without GC_DRAW_TIMEOUT_EN

## Operation
- States: S_WAIT, S_INIT, S_IDLE, S_REG, S_CHECK, S_APPLY, S_DRAW_MAP, S_DRAW_LINK.
- Moore outputs are decoded only from the registered state:
  - init = S_INIT
  - idle = S_IDLE
  - reg_action = S_REG
  - apply_action = S_APPLY
  - draw_map = S_DRAW_MAP
  - draw_link = vga_sel = S_DRAW_LINK
- Transitions:
  - S_WAIT→S_INIT when start=1.
  - S_INIT→S_DRAW_MAP after 1 cycle. This draws the initial frame.
  - S_DRAW_MAP→S_DRAW_LINK on a qualified map_draw_done.
  - S_DRAW_LINK→S_IDLE on a qualified link_draw_done. frame_count increments on this edge.
  - S_IDLE→S_REG when a tick is pending. The pending flag clears on this edge.
  - S_REG→S_CHECK→S_APPLY→S_DRAW_MAP, each lasting exactly 1 cycle. S_CHECK gives the collision detector one cycle to settle on the registered direction.
- Done qualification:
  - A done input is sampled only in its matching draw state, and not in that state's first cycle. This rejects the stale done held over from the previous frame.
  - Done inputs are ignored in all other states.
- Tick counter:
  - Free-runs from reset release, 0..FRAME_TICKS-1, then wraps.
  - Wrap sets the pending flag.
  - If pending is already set at wrap, set frame_overrun. At most one tick is queued.
  - The counter runs in S_WAIT, but pending is held clear there.
- Simultaneous wrap and S_IDLE→S_REG: the transition consumes the old pending flag, then pending is set again. No overrun is flagged.
- frame_count is 8-bit unsigned modulo 256.

## Timing
- Reset (async assert, synchronous-safe release):
  - state = S_WAIT
  - all strobes, draw_map, draw_link, vga_sel = 0
  - frame_count = 0, tick counter = 0, pending = 0, frame_overrun = 0, timeout_err = 0
- Reset asserted mid-draw drops draw_map/draw_link combinationally through the state register. No partial-frame completion.
- Latency:
  - start high → init high on the next clock edge.
  - pending with state S_IDLE → reg_action high 1 cycle later.
  - reg_action → apply_action: exactly 2 cycles.
  - apply_action → draw_map: 1 cycle.
- Minimum draw phase: 2 cycles (first-cycle done is masked).
- vga_sel changes only on state edges. It is never 1 while draw_map=1.

## Configuration
- GC_DRAW_TIMEOUT_EN defined:
  - A per-phase counter clears on entry to S_DRAW_MAP or S_DRAW_LINK.
  - If it reaches DRAW_TIMEOUT-1 with no qualified done, set timeout_err (sticky until reset) and force the normal next state.
  - frame_count still increments when S_DRAW_LINK exits by timeout.
- GC_DRAW_TIMEOUT_EN undefined: draw states wait indefinitely. No timeout counter is built, and timeout_err is a constant 0.

## Test plan
- Reset/start (FRAME_TICKS=16): hold start=0 for 40 cycles → stays in S_WAIT, all outputs 0. Raise start → init=1 for exactly 1 cycle, then draw_map=1.
- Normal frame: map_draw_done after 10 cycles, link_draw_done after 256 cycles. Expected sequence: vga_sel 0→1, then idle=1. On the next tick: reg_action, 1-cycle gap, apply_action, draw_map. frame_count becomes 2 after 2 frames.
- Stale done: hold link_draw_done=1 across entry to S_DRAW_LINK → the first cycle is ignored, and the exit occurs on the 2nd cycle.
- Overrun: with FRAME_TICKS=16, delay map_draw_done 40 cycles → frame_overrun=1 and exactly one queued frame follows. frame_count wraps 255→0 after 256 frames.
- Reset mid-draw: assert reset during S_DRAW_LINK → draw_link and vga_sel are 0 before the next clock edge, and frame_count=0.
- With GC_DRAW_TIMEOUT_EN and DRAW_TIMEOUT=64, never assert map_draw_done → timeout_err=1 at cycle 64 of S_DRAW_MAP, then draw_link=1.
